seq_fixed_mult: RTL and testbench

- Iterative sign-magnitude fixed-point multiplier, parametrised in word width, fraction width and multiplier bits retired per cycle.
- Adds valid/ready handshakes on both sides, round-to-nearest, saturation with an overflow flag, and a zero-operand fast path.
- Sits between neuron-state registers and the update datapath wherever a full combinational N×N multiplier is too costly in area.

---
 rtl/seq_fixed_mult.sv | 120 ++++++++++++
 tb/tb_seq_fixed_mult.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_fixed_mult.sv
// Iterative sign-magnitude fixed-point multiplier: retires BITS_PER_CYCLE multiplier
// bits per cycle, then rounds, saturates and handshakes the result out.
module seq_fixed_mult #(
   parameter int N              = 32,
   parameter int F              = 16,
   parameter int BITS_PER_CYCLE = 1,
   parameter int ROUND          = 1,
   parameter int SATURATE       = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         overflow,
   output logic [1:0]   state_dbg
);

   localparam int M     = N - 1;
   localparam int ITERS = (M + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int PW    = ITERS * BITS_PER_CYCLE;
   localparam int AW    = 2 * M;
   localparam int CW    = $clog2(ITERS + 1);
   localparam int MW    = AW - F + 1;

   // Handshake rule: a transfer happens on a rising edge where valid and ready are
   // both high; valid never drops and payload never changes until that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t              state_q, state_d;
   logic                sign_r;
   logic [M-1:0]        a_mag;
   logic [PW-1:0]       b_sh;
   logic [AW-1:0]       acc;
   logic [CW-1:0]       cnt;

   logic [BITS_PER_CYCLE-1:0] chunk;
   logic [AW-1:0]       term;
   logic [AW-1:0]       acc_sum;
   logic [MW-1:0]       mag_w;
   logic [M-1:0]        mag_o;
   logic                ovf;
   logic                last;
   logic                zero_op;
   logic [N-1:0]        res_c;

   assign state_dbg = state_q;
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign zero_op   = (a[N-2:0] == '0) || (b[N-2:0] == '0);
   assign last      = (cnt == CW'(ITERS - 1));

   // Padding bits of the final chunk are zero, so the shifted partial product fits in AW.
   always_comb begin
      chunk   = b_sh[BITS_PER_CYCLE-1:0];
      term    = (AW'(a_mag) * AW'(chunk)) << (cnt * BITS_PER_CYCLE);
      acc_sum = acc + term;
      mag_w   = {1'b0, acc_sum[AW-1:F]};
      if (ROUND != 0)
         mag_w = mag_w + {{(MW-1){1'b0}}, acc_sum[F-1]};
      ovf   = |mag_w[MW-1:M];
      mag_o = (ovf && (SATURATE != 0)) ? {M{1'b1}} : mag_w[M-1:0];
      res_c = {sign_r & (|mag_o), mag_o};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = zero_op ? DONE : BUSY;
         BUSY:    if (last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_r   <= 1'b0;
         a_mag    <= '0;
         b_sh     <= '0;
         acc      <= '0;
         cnt      <= '0;
         c        <= '0;
         overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_r <= a[N-1] ^ b[N-1];
                  a_mag  <= a[N-2:0];
                  b_sh   <= PW'(b[N-2:0]);
                  acc    <= '0;
                  cnt    <= '0;
                  if (zero_op) begin
                     c        <= '0;
                     overflow <= 1'b0;
                  end
               end
            end
            BUSY: begin
               acc  <= acc_sum;
               b_sh <= b_sh >> BITS_PER_CYCLE;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  c        <= res_c;
                  overflow <= ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_fixed_mult.sv
// Bench for seq_fixed_mult: three instances (default, wrap, truncate) run in lockstep
// on shared operands; table vectors, reset/backpressure sequences and random traffic.
module tb_seq_fixed_mult;

   localparam int N     = 16;
   localparam int F     = 8;
   localparam int BPC   = 2;
   localparam int ITERS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv;
   logic        ordy;
   logic [15:0] a_in, b_in;
   logic        in_rdy [3];
   logic        o_vld  [3];
   logic [15:0] c_o    [3];
   logic        ov_o   [3];
   logic [1:0]  st_o   [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // 0: ROUND=1 SATURATE=1, 1: ROUND=1 SATURATE=0, 2: ROUND=0 SATURATE=1
   seq_fixed_mult #(.N(N), .F(F), .BITS_PER_CYCLE(BPC), .ROUND(1), .SATURATE(1)) dut_main (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_rdy[0]), .a(a_in), .b(b_in),
      .out_valid(o_vld[0]), .out_ready(ordy), .c(c_o[0]), .overflow(ov_o[0]), .state_dbg(st_o[0]));
   seq_fixed_mult #(.N(N), .F(F), .BITS_PER_CYCLE(BPC), .ROUND(1), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_rdy[1]), .a(a_in), .b(b_in),
      .out_valid(o_vld[1]), .out_ready(ordy), .c(c_o[1]), .overflow(ov_o[1]), .state_dbg(st_o[1]));
   seq_fixed_mult #(.N(N), .F(F), .BITS_PER_CYCLE(BPC), .ROUND(0), .SATURATE(1)) dut_trunc (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_rdy[2]), .a(a_in), .b(b_in),
      .out_valid(o_vld[2]), .out_ready(ordy), .c(c_o[2]), .overflow(ov_o[2]), .state_dbg(st_o[2]));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c_main;
      logic [15:0] c_wrap;
      logic [15:0] c_trunc;
      logic [2:0]  ov;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer product of magnitudes, then rounding/overflow rules.
   function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input bit rnd, input bit sat);
      longint p, mag, cm;
      bit     ov, sg;
      p   = longint'(x[14:0]) * longint'(y[14:0]);
      mag = p / 256;
      if (rnd) mag = mag + ((p / 128) % 2);
      ov  = (mag >= 32768);
      cm  = ov ? (sat ? 32767 : (mag % 32768)) : mag;
      sg  = (cm != 0) ? (x[15] ^ y[15]) : 1'b0;
      return {ov, sg, cm[14:0]};
   endfunction

   task automatic do_txn(input logic [15:0] x, input logic [15:0] y, input int hold,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [2:0] eov);
      int lat;
      int exp_lat;
      logic [15:0] ec [3];
      ec[0] = e0; ec[1] = e1; ec[2] = e2;
      exp_lat = (x[14:0] == 0 || y[14:0] == 0) ? 1 : ITERS + 1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk($sformatf("in_ready_idle%0d", k), in_rdy[k], 1);
      a_in = x; b_in = y; iv = 1'b1; ordy = 1'b0;
      @(negedge clk);
      iv = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
      lat = 1;
      while (!o_vld[0] && lat < ITERS + 6) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, exp_lat);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("out_valid%0d", k), o_vld[k], 1);
         chk($sformatf("c%0d a=%h b=%h", k, x, y), c_o[k], ec[k]);
         chk($sformatf("ovf%0d a=%h b=%h", k, x, y), ov_o[k], eov[k]);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", o_vld[0], 1);
         chk("hold_in_ready", in_rdy[0], 0);
         chk("hold_c", c_o[0], ec[0]);
         chk("hold_ovf", ov_o[0], eov[0]);
      end
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      chk("post_valid", o_vld[0], 0);
      chk("post_in_ready", in_rdy[0], 1);
      chk("post_c_kept", c_o[0], ec[0]);
   endtask

   task automatic rand_txn(input logic [15:0] x, input logic [15:0] y, input int hold);
      logic [16:0] m0, m1, m2;
      m0 = model(x, y, 1'b1, 1'b1);
      m1 = model(x, y, 1'b1, 1'b0);
      m2 = model(x, y, 1'b0, 1'b1);
      do_txn(x, y, hold, m0[15:0], m1[15:0], m2[15:0], {m2[16], m1[16], m0[16]});
   endtask

   initial begin
      vecs[0] = '{16'h0180, 16'h0200, 16'h0300, 16'h0300, 16'h0300, 3'b000};
      vecs[1] = '{16'h8180, 16'h0200, 16'h8300, 16'h8300, 16'h8300, 3'b000};
      vecs[2] = '{16'h8180, 16'h8200, 16'h0300, 16'h0300, 16'h0300, 3'b000};
      vecs[3] = '{16'h7F00, 16'h0200, 16'h7FFF, 16'h7E00, 16'h7FFF, 3'b111};
      vecs[4] = '{16'hFF00, 16'h0200, 16'hFFFF, 16'hFE00, 16'hFFFF, 3'b111};
      vecs[5] = '{16'h0001, 16'h0080, 16'h0001, 16'h0001, 16'h0000, 3'b000};
      vecs[6] = '{16'h8001, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 3'b000};
      vecs[7] = '{16'h8000, 16'h8123, 16'h0000, 16'h0000, 16'h0000, 3'b000};

      rst = 1'b1; iv = 1'b1; ordy = 1'b1; a_in = 16'h0180; b_in = 16'h0200;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_state%0d", k), st_o[k], 0);
         chk($sformatf("rst_in_ready%0d", k), in_rdy[k], 0);
         chk($sformatf("rst_out_valid%0d", k), o_vld[k], 0);
         chk($sformatf("rst_c%0d", k), c_o[k], 0);
         chk($sformatf("rst_ovf%0d", k), ov_o[k], 0);
      end
      iv = 1'b0; ordy = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].a, vecs[i].b, (i == 3) ? 5 : 0,
                vecs[i].c_main, vecs[i].c_wrap, vecs[i].c_trunc, vecs[i].ov);

      // Abort a busy operation with reset: no result may appear, c must clear.
      @(negedge clk);
      a_in = 16'h0180; b_in = 16'h0200; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", st_o[0], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_state", st_o[0], 0);
      chk("abort_out_valid", o_vld[0], 0);
      chk("abort_c", c_o[0], 0);
      repeat (ITERS + 2) begin
         @(negedge clk);
         chk("abort_no_result", o_vld[0], 0);
      end
      do_txn(16'h0280, 16'h8300, 0, 16'h8780, 16'h8780, 16'h8780, 3'b000);

      for (int i = 0; i < 40; i++) begin
         logic [15:0] x, y;
         x = {1'($urandom), 15'($urandom) >> $urandom_range(0, 14)};
         y = {1'($urandom), 15'($urandom) >> $urandom_range(0, 14)};
         if (i % 10 == 0) y[14:0] = 15'd0;
         rand_txn(x, y, $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
